// File: rtl/amdf_pkg.sv
// Shared types and constants for the AMDF pitch controller and its serial divider.
package amdf_pkg;

  typedef enum logic [2:0] {
    FILL,
    ACCUM,
    DIVIDE,
    COMPARE,
    OUT
  } state_t;

  localparam int ACC_W     = 32;
  localparam int DIV_STEPS = 32;

  function automatic int lag_w(input int l_max);
    return $clog2(l_max + 1);
  endfunction

endpackage

// File: rtl/amdf_div_serial.sv
// 32-bit restoring shift-subtract divider; one quotient bit per cycle, done on the last step.
module amdf_div_serial
  import amdf_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);

  localparam int STEP_W = $clog2(DIV_STEPS);

  logic [ACC_W-1:0]  rem, q, d;
  logic [STEP_W-1:0] step;
  logic              running;
  logic [ACC_W:0]    rem_sh;
  logic              fits;

  // The quotient register doubles as the dividend shift register.
  assign rem_sh   = {rem, q[ACC_W-1]};
  assign fits     = rem_sh >= {1'b0, d};
  assign done     = running && (step == STEP_W'(DIV_STEPS - 1));
  assign quotient = q[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      step    <= '0;
      rem     <= '0;
      q       <= '0;
      d       <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      rem     <= '0;
      q       <= dividend;
      d       <= divisor;
    end else if (running) begin
      rem  <= fits ? ACC_W'(rem_sh - {1'b0, d}) : rem_sh[ACC_W-1:0];
      q    <= {q[ACC_W-2:0], fits};
      step <= step + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/amdf_pitch_ctrl.sv
// Time-multiplexed AMDF pitch estimator: buffers one frame, then walks lags L_MIN..L_MAX
// through a shared abs-diff accumulator and serial divider, reporting the minimum-AMDF lag.
module amdf_pitch_ctrl
  import amdf_pkg::*;
#(
  parameter  int N     = 12,
  parameter  int L_MIN = 4,
  parameter  int L_MAX = 8,
  parameter  int W     = 16,
  localparam int LAG_W = lag_w(L_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LAG_W-1:0] res_lag,
  output logic [W-1:0]     res_amdf,
  output logic             busy
);

  localparam int IDX_W = $clog2(N);

  state_t           state, state_n;
  logic [W-1:0]     fbuf [N];
  logic [IDX_W-1:0] cnt, i;
  logic [LAG_W-1:0] k, best_lag;
  logic [ACC_W-1:0] sum, sum_n, divisor;
  logic [W-1:0]     best, quotient, term;
  logic             s_fire, last_term, last_lag, better, div_start, div_done;

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign s_ready   = (state == FILL);
  assign res_valid = (state == OUT);
  assign busy      = (state != FILL);
  assign s_fire    = s_ready && s_valid;

  assign term      = abs_diff(fbuf[i], fbuf[i + IDX_W'(k)]);
  assign sum_n     = sum + ACC_W'(term);
  assign last_term = (ACC_W'(i) + ACC_W'(k) == ACC_W'(N - 1));
  assign last_lag  = (k == LAG_W'(L_MAX));
  assign divisor   = ACC_W'(N) - ACC_W'(k);
  // The divider is loaded with the final sum on the last ACCUM cycle, so DIVIDE lasts exactly DIV_STEPS.
  assign div_start = (state == ACCUM) && last_term;
  assign better    = quotient < best;

  amdf_div_serial #(.OUT_W(W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sum_n),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FILL:    if (s_fire && cnt == IDX_W'(N - 1)) state_n = ACCUM;
      ACCUM:   if (last_term) state_n = DIVIDE;
      DIVIDE:  if (div_done) state_n = COMPARE;
      COMPARE: state_n = last_lag ? OUT : ACCUM;
      OUT:     if (res_ready) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_fire) fbuf[cnt] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      i        <= '0;
      k        <= '0;
      sum      <= '0;
      best     <= '0;
      best_lag <= '0;
      res_lag  <= '0;
      res_amdf <= '0;
    end else begin
      case (state)
        FILL: if (s_fire) begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(N - 1)) begin
            k        <= LAG_W'(L_MIN);
            i        <= '0;
            sum      <= '0;
            best     <= '1;
            best_lag <= LAG_W'(L_MIN);
          end
        end
        ACCUM: begin
          sum <= sum_n;
          i   <= i + 1'b1;
        end
        COMPARE: begin
          // Strict compare: ties keep the smaller lag found earlier.
          if (better) begin
            best     <= quotient;
            best_lag <= k;
          end
          if (last_lag) begin
            res_amdf <= better ? quotient : best;
            res_lag  <= better ? k : best_lag;
          end else begin
            k   <= k + 1'b1;
            i   <= '0;
            sum <= '0;
          end
        end
        OUT: if (res_ready) cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_amdf_pitch_ctrl.sv
// Bench for amdf_pitch_ctrl: table of frames with a scoreboard, plus backpressure, reset and override cases.
module tb_amdf_pitch_ctrl;

  localparam int N = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, res_valid, res_ready, busy;
  logic [15:0] s_data, res_amdf;
  logic [3:0]  res_lag;
  logic        b_s_valid, b_s_ready, b_res_valid, b_res_ready, b_busy;
  logic [15:0] b_s_data, b_res_amdf;
  logic [2:0]  b_res_lag;

  always #5 clk = ~clk;

  amdf_pitch_ctrl dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_lag(res_lag), .res_amdf(res_amdf), .busy(busy)
  );

  amdf_pitch_ctrl #(.N(12), .L_MIN(5), .L_MAX(5), .W(16)) dut_b (
    .clk(clk), .reset(reset), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_lag(b_res_lag), .res_amdf(b_res_amdf),
    .busy(b_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct { int lag; int amdf; } exp_t;
  typedef struct { int kind; int lag; int amdf; } vec_t;
  exp_t sb[$];
  vec_t vecs[4];
  int   rnd[N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // kinds: 0 period-5, 1 ramp, 2 constant, 3 random, 4 alternating 0/65535
  function automatic int sample(input int kind, input int j);
    case (kind)
      0: return (j % 5) * 100;
      1: return 10 * j;
      2: return 777;
      3: return rnd[j];
      4: return (j % 2 == 1) ? 65535 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic void ref_model(input int kind, input int lmin, input int lmax,
                                    output int lag, output int amdf);
    int     best;
    longint s;
    int     d;
    best = 65535;
    lag  = lmin;
    for (int k = lmin; k <= lmax; k++) begin
      s = 0;
      for (int i = 0; i < N - k; i++) begin
        d = sample(kind, i) - sample(kind, i + k);
        s += (d < 0) ? -d : d;
      end
      if (int'(s / (N - k)) < best) begin
        best = int'(s / (N - k));
        lag  = k;
      end
    end
    amdf = best;
  endfunction

  task automatic send_frame(input int kind, output int t_last);
    int guard;
    t_last = 0;
    for (int j = 0; j < N; j++) begin
      s_valid = 1'b1;
      s_data  = 16'(sample(kind, j));
      guard   = 0;
      while (!s_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready) timeout_fail("send_frame");
      t_last = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Waits for res_valid, then checks latency and the popped expected result.
  task automatic check_result(input string tag, input int t_last);
    int   guard;
    exp_t e;
    guard = 0;
    while (!res_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!res_valid) begin
      timeout_fail({tag, "_res_valid"});
    end else begin
      chk({tag, "_latency"}, cyc - t_last, 196);
      if (sb.size() == 0) begin
        timeout_fail({tag, "_scoreboard_empty"});
      end else begin
        e = sb.pop_front();
        chk({tag, "_lag"}, res_lag, e.lag);
        chk({tag, "_amdf"}, res_amdf, e.amdf);
      end
      chk({tag, "_busy_in_out"}, busy, 1);
      chk({tag, "_s_ready_in_out"}, s_ready, 0);
    end
  endtask

  initial begin
    int   t_last, l, a, guard, t_b;
    exp_t e;

    reset = 1'b1;
    s_valid = 1'b0; s_data = '0; res_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_res_ready = 1'b1;
    for (int j = 0; j < N; j++) rnd[j] = int'($urandom_range(0, 65535));
    ref_model(3, 4, 8, l, a);
    vecs[0] = '{0, 5, 0};
    vecs[1] = '{1, 4, 40};
    vecs[2] = '{2, 4, 0};
    vecs[3] = '{3, l, a};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_lag", res_lag, 0);
    chk("rst_res_amdf", res_amdf, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].kind, t_last);
      sb.push_back('{vecs[v].lag, vecs[v].amdf});
      check_result($sformatf("vec%0d", v), t_last);
      @(negedge clk);
      chk($sformatf("vec%0d_released", v), res_valid, 0);
    end

    // Backpressure: hold the result, offer a junk sample that must not be taken.
    res_ready = 1'b0;
    send_frame(1, t_last);
    sb.push_back('{4, 40});
    check_result("bp", t_last);
    s_valid = 1'b1;
    s_data  = 16'd12345;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_lag", res_lag, 4);
      chk("bp_hold_amdf", res_amdf, 40);
      chk("bp_hold_s_ready", s_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", res_valid, 0);
    chk("bp_after_hs_s_ready", s_ready, 1);
    send_frame(0, t_last);
    sb.push_back('{5, 0});
    check_result("bp_frame2", t_last);
    @(negedge clk);

    // Reset in the middle of lag 6 accumulation.
    send_frame(1, t_last);
    guard = 0;
    while (cyc < t_last + 84 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_lag", res_lag, 0);
    chk("mid_rst_res_amdf", res_amdf, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    send_frame(0, t_last);
    sb.push_back('{5, 0});
    check_result("post_rst", t_last);
    @(negedge clk);

    // Single-lag instance: full-scale alternating frame.
    t_b = 0;
    for (int j = 0; j < N; j++) begin
      b_s_valid = 1'b1;
      b_s_data  = 16'(sample(4, j));
      guard = 0;
      while (!b_s_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (!b_s_ready) timeout_fail("b_send");
      t_b = cyc;
      @(negedge clk);
    end
    b_s_valid = 1'b0;
    ref_model(4, 5, 5, l, a);
    sb.push_back('{l, a});
    guard = 0;
    while (!b_res_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!b_res_valid) begin
      timeout_fail("b_res_valid");
    end else begin
      e = sb.pop_front();
      chk("b_latency", cyc - t_b, 41);
      chk("b_lag", b_res_lag, e.lag);
      chk("b_amdf", b_res_amdf, e.amdf);
      chk("b_amdf_full_scale", b_res_amdf, 65535);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
